// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the lock-in control blocks: register map, bit
// indices, sweep state encoding and frequency-word defaults.
package nco_ctrl_pkg;

  localparam int FREQ_W_DEF     = 20;
  localparam int RESET_FREQ_DEF = 1310;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_START  = 3'd1;
  localparam logic [2:0] ADDR_STOP   = 3'd2;
  localparam logic [2:0] ADDR_STEP   = 3'd3;
  localparam logic [2:0] ADDR_DWELL  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_FREQ   = 3'd6;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_CONT_BIT  = 2;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    STEP  = 2'd3
  } sweep_state_e;

  // A dwell of zero behaves as a one-cycle dwell.
  function automatic logic [31:0] nz32(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/nco_sweep_dwell_timer.sv
// Dwell down-counter: o_expire is high during the last cycle of a dwell,
// so a reload on that edge gives back-to-back holds of exactly N cycles.
module nco_sweep_dwell_timer
  import nco_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_en,
  output logic        o_expire
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= nz32(i_load_val);
    end else if (i_en && (r_count != 32'd0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_expire = (r_count == 32'd1);

endmodule

// File: rtl/nco_freq_sweep_ctrl.sv
// Avalon-MM frequency sweep scheduler for one lock-in NCO phase-increment word.
//
// state | meaning
// IDLE  | no sweep; out_port is a plain writable register
// LOAD  | edge action: out_port <- start value, strobe, dwell reloaded
// DWELL | holding the current value until the dwell timer expires
// STEP  | edge action: out_port <- next (clamped) value, strobe, dwell reloaded
// LOAD and STEP take no cycle of their own; they happen on the edge leaving
// IDLE/DWELL so that each value is held exactly max(DWELL,1) cycles.
module nco_freq_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int RESET_FREQ = RESET_FREQ_DEF
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [FREQ_W-1:0] out_port,
  output logic              step_strobe,
  output logic              busy
);

  localparam logic [FREQ_W-1:0] RST_F = FREQ_W'(RESET_FREQ);

  logic [FREQ_W-1:0] r_start_freq;
  logic [FREQ_W-1:0] r_stop_freq;
  logic [FREQ_W-1:0] r_step;
  logic [31:0]       r_dwell;
  logic              r_cont;
  logic              r_done;
  logic              r_busy;
  logic              r_strobe;
  logic [FREQ_W-1:0] r_out;
  sweep_state_e      r_state;

  logic [FREQ_W-1:0] r_wk_start;
  logic [FREQ_W-1:0] r_wk_stop;
  logic [FREQ_W-1:0] r_wk_step;
  logic [31:0]       r_wk_dwell;
  logic              r_wk_up;

  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_abort;
  logic              w_start;
  logic              w_expire;
  logic              w_set_done;
  sweep_state_e      w_act;
  logic [FREQ_W:0]   w_sum;
  logic [FREQ_W:0]   w_diff;
  logic [FREQ_W-1:0] w_next;
  logic [31:0]       w_tmr_val;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr && (address == ADDR_CTRL);
  assign w_abort   = w_wr_ctrl & writedata[CTRL_ABORT_BIT];
  assign w_start   = w_wr_ctrl & writedata[CTRL_START_BIT] & ~w_abort;

  // One extra bit catches wrap past either end of the word range.
  assign w_sum  = {1'b0, r_out} + {1'b0, r_wk_step};
  assign w_diff = {1'b0, r_out} - {1'b0, r_wk_step};

  always_comb begin
    w_next = r_wk_stop;
    if (r_wk_up) begin
      if (!w_sum[FREQ_W] && (w_sum[FREQ_W-1:0] <= r_wk_stop)) w_next = w_sum[FREQ_W-1:0];
    end else begin
      if (!w_diff[FREQ_W] && (w_diff[FREQ_W-1:0] >= r_wk_stop)) w_next = w_diff[FREQ_W-1:0];
    end
  end

  always_comb begin
    w_act      = r_state;
    w_set_done = 1'b0;
    if (w_abort) begin
      w_act = IDLE;
    end else if (w_start) begin
      w_act = LOAD;
    end else if ((r_state == DWELL) && w_expire) begin
      if (r_out == r_wk_stop) begin
        if (r_cont) begin
          w_act = LOAD;
        end else begin
          w_act      = IDLE;
          w_set_done = 1'b1;
        end
      end else begin
        w_act = STEP;
      end
    end
  end

  assign w_tmr_val = w_start ? r_dwell : r_wk_dwell;

  nco_sweep_dwell_timer u_dwell_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     ((w_act == LOAD) || (w_act == STEP)),
    .i_load_val (w_tmr_val),
    .i_en       (r_state == DWELL),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_start_freq <= RST_F;
      r_stop_freq  <= RST_F;
      r_step       <= FREQ_W'(1);
      r_dwell      <= 32'd0;
      r_cont       <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_strobe     <= 1'b0;
      r_out        <= RST_F;
      r_state      <= IDLE;
      r_wk_start   <= RST_F;
      r_wk_stop    <= RST_F;
      r_wk_step    <= FREQ_W'(1);
      r_wk_dwell   <= 32'd0;
      r_wk_up      <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      if (w_wr) begin
        case (address)
          ADDR_CTRL:  r_cont       <= writedata[CTRL_CONT_BIT];
          ADDR_START: r_start_freq <= writedata[FREQ_W-1:0];
          ADDR_STOP:  r_stop_freq  <= writedata[FREQ_W-1:0];
          ADDR_STEP:  r_step       <= writedata[FREQ_W-1:0];
          ADDR_DWELL: r_dwell      <= writedata;
          default: ;
        endcase
      end

      case (w_act)
        LOAD: begin
          r_state  <= DWELL;
          r_busy   <= 1'b1;
          r_strobe <= 1'b1;
          if (w_start) begin
            r_out      <= r_start_freq;
            r_wk_start <= r_start_freq;
            r_wk_stop  <= r_stop_freq;
            r_wk_step  <= (r_step == '0) ? FREQ_W'(1) : r_step;
            r_wk_dwell <= r_dwell;
            r_wk_up    <= (r_start_freq <= r_stop_freq);
            r_done     <= 1'b0;
          end else begin
            r_out <= r_wk_start;
          end
        end
        STEP: begin
          r_state  <= DWELL;
          r_out    <= w_next;
          r_strobe <= 1'b1;
        end
        DWELL: begin
          r_state <= DWELL;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (w_set_done) r_done <= 1'b1;
          // Frequency writes only land when no sweep owns out_port.
          if (w_wr && (address == ADDR_FREQ) && (r_state == IDLE)) begin
            r_out <= writedata[FREQ_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:   readdata[CTRL_CONT_BIT] = r_cont;
      ADDR_START:  readdata[FREQ_W-1:0]    = r_start_freq;
      ADDR_STOP:   readdata[FREQ_W-1:0]    = r_stop_freq;
      ADDR_STEP:   readdata[FREQ_W-1:0]    = r_step;
      ADDR_DWELL:  readdata                = r_dwell;
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT] = r_busy;
        readdata[STAT_DONE_BIT] = r_done;
      end
      ADDR_FREQ:   readdata[FREQ_W-1:0]    = r_out;
      default: ;
    endcase
  end

  assign out_port    = r_out;
  assign step_strobe = r_strobe;
  assign busy        = r_busy;

endmodule

// File: tb/tb_nco_freq_sweep_ctrl.sv
// Directed and randomized sweeps against a list-based model of the sweep rules.
module tb_nco_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [19:0] out_port;
  logic        step_strobe;
  logic        busy;

  int checks = 0;
  int errors = 0;
  longint exp_q[$];

  nco_freq_sweep_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .step_strobe (step_strobe),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge; the write is taken on the following rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // List of values the word must take: start, then steps toward stop, clamped.
  task automatic build_model(input longint s, input longint p, input longint st);
    longint v;
    longint stp;
    exp_q.delete();
    stp = (st == 0) ? 1 : st;
    v = s;
    exp_q.push_back(v);
    while (v != p) begin
      if (s <= p) v = (v + stp > p) ? p : v + stp;
      else        v = (v - stp < p) ? p : v - stp;
      exp_q.push_back(v);
    end
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] st, input logic [31:0] dw);
    longint d_eff;
    logic [31:0] rv;
    build_model(longint'(s), longint'(p), longint'(st));
    d_eff = (dw == 0) ? 1 : longint'(dw);
    wr(3'd1, s);
    wr(3'd2, p);
    wr(3'd3, st);
    wr(3'd4, dw);
    wr(3'd0, 32'h1);
    rd(3'd5, rv);
    chk("status_running", rv, 32'h1);
    foreach (exp_q[i]) begin
      for (longint c = 0; c < d_eff; c++) begin
        chk("sweep_out", 32'(out_port), 32'(exp_q[i]));
        chk("sweep_strobe", 32'(step_strobe), 32'(c == 0));
        chk("sweep_busy", 32'(busy), 32'h1);
        @(negedge clk);
      end
    end
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_out", 32'(out_port), p);
    chk("end_strobe", 32'(step_strobe), 32'h0);
    rd(3'd5, rv);
    chk("end_status_done", rv, 32'h2);
    rd(3'd6, rv);
    chk("end_freq_read", rv, p);
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] rs, rp, rst_v, rdw;
    longint lo, hi, dl;

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_out", 32'(out_port), 32'd1310);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(step_strobe), 32'd0);
    rd(3'd2, rv); chk("rst_stop_reg", rv, 32'd1310);
    rd(3'd1, rv); chk("rst_start_reg", rv, 32'd1310);
    rd(3'd3, rv); chk("rst_step_reg", rv, 32'd1);
    rd(3'd4, rv); chk("rst_dwell_reg", rv, 32'd0);
    rd(3'd5, rv); chk("rst_status", rv, 32'd0);
    rd(3'd0, rv); chk("rst_ctrl", rv, 32'd0);
    rd(3'd7, rv); chk("rst_addr7", rv, 32'd0);
    @(negedge clk);

    run_sweep(32'd100, 32'd110, 32'd4, 32'd3);
    run_sweep(32'd50, 32'd40, 32'd3, 32'd0);
    run_sweep(32'hFFFF0, 32'hFFFFF, 32'h20, 32'd1);
    run_sweep(32'h10, 32'h0, 32'h30, 32'd2);
    run_sweep(32'd7, 32'd9, 32'd0, 32'd1);
    run_sweep(32'd33, 32'd33, 32'd5, 32'd2);

    for (int n = 0; n < 8; n++) begin
      rs  = 32'($urandom_range(0, 20'hFFFFF));
      dl  = longint'($urandom_range(0, 60));
      if ($urandom_range(0, 1) == 1) begin
        hi = longint'(rs) + dl;
        rp = (hi > 64'hFFFFF) ? 32'hFFFFF : 32'(hi);
      end else begin
        lo = longint'(rs) - dl;
        rp = (lo < 0) ? 32'd0 : 32'(lo);
      end
      rst_v = 32'($urandom_range(0, 25));
      rdw   = 32'($urandom_range(0, 4));
      run_sweep(rs, rp, rst_v, rdw);
    end

    // Continuous sweep, ignored FREQ write while busy, then abort.
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd12);
    wr(3'd3, 32'd1);
    wr(3'd4, 32'd2);
    wr(3'd0, 32'h5);
    for (int k = 0; k <= 8; k++) begin
      chk("cont_out", 32'(out_port), 32'(10 + (k / 2) % 3));
      chk("cont_strobe", 32'(step_strobe), 32'(k % 2 == 0));
      chk("cont_busy", 32'(busy), 32'h1);
      if (k == 3) wr(3'd6, 32'd500);
      else if (k != 8) @(negedge clk);
    end
    wr(3'd0, 32'h2);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_out", 32'(out_port), 32'd11);
    chk("abort_strobe", 32'(step_strobe), 32'h0);
    rd(3'd5, rv); chk("abort_status", rv, 32'h0);
    @(negedge clk);
    chk("abort_hold_out", 32'(out_port), 32'd11);
    wr(3'd6, 32'd500);
    chk("idle_freq_out", 32'(out_port), 32'd500);
    chk("idle_freq_strobe", 32'(step_strobe), 32'h0);
    rd(3'd6, rv); chk("idle_freq_read", rv, 32'd500);

    // Restart mid-sweep with a freshly written START_FREQ.
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd110);
    wr(3'd3, 32'd4);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'h1);
    for (int k = 0; k <= 4; k++) begin
      chk("rs_out", 32'(out_port), (k < 3) ? 32'd100 : 32'd104);
      if (k == 2) wr(3'd1, 32'd200);
      else if (k != 4) @(negedge clk);
    end
    wr(3'd0, 32'h1);
    chk("restart_out", 32'(out_port), 32'd200);
    chk("restart_strobe", 32'(step_strobe), 32'h1);
    chk("restart_busy", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    chk("restart_hold", 32'(out_port), 32'd200);
    chk("restart_hold_strobe", 32'(step_strobe), 32'h0);
    @(negedge clk);
    chk("restart_step", 32'(out_port), 32'd196);
    chk("restart_step_strobe", 32'(step_strobe), 32'h1);
    wr(3'd0, 32'h3);
    chk("startabort_busy", 32'(busy), 32'h0);
    chk("startabort_out", 32'(out_port), 32'd196);
    rd(3'd5, rv); chk("startabort_status", rv, 32'h0);
    wr(3'd0, 32'h3);
    chk("startabort_idle_busy", 32'(busy), 32'h0);
    chk("startabort_idle_strobe", 32'(step_strobe), 32'h0);
    chk("startabort_idle_out", 32'(out_port), 32'd196);

    // Reset pulsed in the middle of a sweep.
    wr(3'd1, 32'd1000);
    wr(3'd2, 32'd2000);
    wr(3'd3, 32'd1);
    wr(3'd4, 32'd5);
    wr(3'd0, 32'h5);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_out", 32'(out_port), 32'd1310);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_strobe", 32'(step_strobe), 32'h0);
    rd(3'd5, rv); chk("midrst_status", rv, 32'h0);
    rd(3'd1, rv); chk("midrst_start_reg", rv, 32'd1310);
    rd(3'd4, rv); chk("midrst_dwell_reg", rv, 32'd0);
    rd(3'd0, rv); chk("midrst_ctrl", rv, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_hold_out", 32'(out_port), 32'd1310);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
